mac_pipe_signed: RTL and testbench
==================================

Name: mac_pipe_signed

Overview:
- Parametrised, pipelined multiply-accumulate unit for the accelerator datapath. It generalises the 8x8 signed multiplier in four ways: configurable operand and accumulator widths, per-group signed/unsigned mode, saturating accumulation, and valid/ready flow control.
- Operand streams are grouped by first/last flags, for example one dot-product row. One result is emitted per group.

Parameters:
- DATA_W, 8, operand width in bits; legal range is at least 2.
- ACC_W, 32, accumulator and result width; must be at least 2*DATA_W+1.
- SATURATE, 1, selects overflow handling. 1 = clamp. 0 = wrap modulo 2^ACC_W. The overflow flag is reported in both cases.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  input beat valid.
- in_ready  out  1  unit can accept a beat.
- in_a  in  DATA_W  operand A.
- in_b  in  DATA_W  operand B.
- in_signed  in  1  1 = two's-complement operands, 0 = unsigned. Sampled on the first beat only.
- in_first  in  1  beat starts a new accumulation group.
- in_last  in  1  beat ends the group; produces a result.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts the result.
- out_data  out  ACC_W  accumulated result.
- out_sat  out  1  overflow occurred during this group (sticky across the group).

Behaviour:
- Reset values: in_ready=1, out_valid=0, out_data=0, out_sat=0. Also cleared: accumulator, group mode (unsigned), sticky flag, and all stage valids. A partial group in flight is discarded.
- Accept: a beat transfers on an edge where in_valid && in_ready.
- Stall: stall = out_valid && !out_ready. While stalled:
  - in_ready=0;
  - every pipeline register holds its value;
  - out_data and out_sat stay stable.
- in_ready = !stall, combinational.
- Pipeline: three register stages.
  - S1: registers operands, flags and mode.
  - S2: registers the product.
  - S3: accumulator and output register.
- Latency: a beat presented and accepted in cycle t with in_last=1 gives out_valid=1 in cycle t+3 when there is no stall. Throughput is one beat per cycle.
- Product width and extension:
  - Signed mode: the 2*DATA_W-bit signed product is sign-extended to ACC_W.
  - Unsigned mode: the product is zero-extended.
- Group mode is latched from in_signed on a beat with in_first=1. It applies to every beat until the next first beat; in_signed on other beats is ignored.
- Accumulate, at S3 on each beat:
  - base = in_first ? 0 : acc;
  - sum = base + ext_product, computed in ACC_W+1 bits.
- Overflow detection:
  - Signed: the ACC_W+1-bit sign-extended sum differs from its ACC_W-bit truncation.
  - Unsigned: carry out of bit ACC_W-1.
- On overflow with SATURATE=1:
  - signed clamps to 2^(ACC_W-1)-1 or -2^(ACC_W-1), according to the direction of the product sign;
  - unsigned clamps to 2^ACC_W-1.
- On overflow with SATURATE=0 the value wraps.
- Sticky flag: cleared by a first beat, then ORed with the overflow of each beat, including the first beat itself.
- On a last beat, S3 loads out_data with the new acc value and out_sat with the sticky flag, and sets out_valid=1.
  - out_valid clears on an edge where out_ready=1, unless a new last beat completes on the same edge; in that case out_valid stays 1 with the new data.
- Clearing the accumulator: it is not cleared by in_last. The next group must begin with in_first.
- A beat without in_first and with no prior first (after reset) accumulates onto 0, in unsigned mode.
- in_first && in_last on the same beat: the result is the single product (overflow is impossible given the ACC_W constraint).
- Stages holding no valid beat do not alter acc.
- Reset asserted mid-group or during a stall: outputs return to reset values on that edge and the held result is lost.

Test Plan:
- Signed single beat: a=-128, b=-128, first=last=1, signed → out_data=16384, out_sat=0, out_valid exactly in cycle t+3.
- Unsigned single beat: a=255, b=255, first=last=1, unsigned → out_data=65025. The same bits in signed mode (-1*-1) → 1.
- Signed 4-beat group, back-to-back: (3,-4), (-5,6), (127,127), (-128,1) → out_data=15959, one out_valid pulse only.
- Saturation, instance ACC_W=17, SATURATE=1: four beats of (-128,-128), signed → out_data=65535, out_sat=1. Repeat with SATURATE=0 → out_data=-65536, out_sat=1. A next single group (2,3) → 6, out_sat=0.
- Backpressure: two 2-beat groups (1,1),(2,2) and (3,3),(4,4) streamed back-to-back with out_ready=0 for 5 cycles after the first result → in_ready=0 while stalled, first result 5 held stable, then second result 25, no beat lost or duplicated.
- Reset mid-group: first beat (10,10), then rst for 1 cycle → all outputs 0. Then beat (2,2) with last but no first → out_data=4.

Source files
------------

// File: rtl/mac_pipe_signed.sv
// Pipelined signed/unsigned multiply-accumulate with per-group mode, saturating
// or wrapping accumulation, sticky overflow reporting and valid/ready flow control.
module mac_pipe_signed #(
   parameter int DATA_W   = 8,
   parameter int ACC_W    = 32,
   parameter int SATURATE = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_a,
   input  logic [DATA_W-1:0] in_b,
   input  logic              in_signed,
   input  logic              in_first,
   input  logic              in_last,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [ACC_W-1:0]  out_data,
   output logic              out_sat
);

   localparam int PROD_W = 2 * DATA_W;

   // Full product widened to the accumulator, sign- or zero-extended by group mode.
   function automatic logic signed [ACC_W-1:0] ext_product(
      input logic [DATA_W-1:0] a,
      input logic [DATA_W-1:0] b,
      input logic              sgn
   );
      logic signed [PROD_W-1:0] as;
      logic signed [PROD_W-1:0] bs;
      logic signed [PROD_W-1:0] ps;
      logic [PROD_W-1:0]        au;
      logic [PROD_W-1:0]        bu;
      logic [PROD_W-1:0]        pu;
      as = {{DATA_W{a[DATA_W-1]}}, a};
      bs = {{DATA_W{b[DATA_W-1]}}, b};
      au = {{DATA_W{1'b0}}, a};
      bu = {{DATA_W{1'b0}}, b};
      ps = as * bs;
      pu = au * bu;
      if (sgn)
         return {{(ACC_W-PROD_W){ps[PROD_W-1]}}, ps};
      else
         return {{(ACC_W-PROD_W){1'b0}}, pu};
   endfunction

   // Returns {overflow, result}; the clamp direction follows the product sign.
   function automatic logic [ACC_W:0] sat_add(
      input logic signed [ACC_W-1:0] base,
      input logic signed [ACC_W-1:0] prod,
      input logic                    sgn
   );
      logic [ACC_W:0]   sum;
      logic             ovf;
      logic [ACC_W-1:0] res;
      if (sgn) begin
         sum = {base[ACC_W-1], base} + {prod[ACC_W-1], prod};
         ovf = sum[ACC_W] != sum[ACC_W-1];
      end else begin
         sum = {1'b0, base} + {1'b0, prod};
         ovf = sum[ACC_W];
      end
      res = sum[ACC_W-1:0];
      if (ovf && (SATURATE != 0)) begin
         if (!sgn)
            res = '1;
         else if (prod[ACC_W-1])
            res = {1'b1, {(ACC_W-1){1'b0}}};
         else
            res = {1'b0, {(ACC_W-1){1'b1}}};
      end
      return {ovf, res};
   endfunction

   logic stall;
   logic accept;
   logic mode;
   logic beat_sgn;

   assign stall    = out_valid && !out_ready;
   assign in_ready = !stall;
   assign accept   = in_valid && in_ready;
   assign beat_sgn = in_first ? in_signed : mode;

   // ---- S1: operands, flags and resolved group mode ----
   logic              vld_p0;
   logic              first_p0;
   logic              last_p0;
   logic              sgn_p0;
   logic [DATA_W-1:0] a_p0;
   logic [DATA_W-1:0] b_p0;

   always_ff @(posedge clk) begin
      if (rst) begin
         vld_p0 <= 1'b0;
         mode   <= 1'b0;
      end else if (!stall) begin
         vld_p0 <= accept;
         if (accept && in_first)
            mode <= in_signed;
      end
   end

   always_ff @(posedge clk) begin
      if (accept) begin
         a_p0     <= in_a;
         b_p0     <= in_b;
         first_p0 <= in_first;
         last_p0  <= in_last;
         sgn_p0   <= beat_sgn;
      end
   end

   // ---- S2: extended product ----
   logic                    vld_p1;
   logic                    first_p1;
   logic                    last_p1;
   logic                    sgn_p1;
   logic signed [ACC_W-1:0] prod_p1;

   always_ff @(posedge clk) begin
      if (rst)
         vld_p1 <= 1'b0;
      else if (!stall)
         vld_p1 <= vld_p0;
   end

   always_ff @(posedge clk) begin
      if (!stall && vld_p0) begin
         prod_p1  <= ext_product(a_p0, b_p0, sgn_p0);
         first_p1 <= first_p0;
         last_p1  <= last_p0;
         sgn_p1   <= sgn_p0;
      end
   end

   // ---- S3: accumulator, sticky overflow and output register ----
   logic signed [ACC_W-1:0] acc_p2;
   logic                    sticky_p2;
   logic signed [ACC_W-1:0] base;
   logic [ACC_W:0]          add_res;
   logic                    ovf;
   logic [ACC_W-1:0]        acc_nxt;
   logic                    sticky_nxt;

   always_comb begin
      base       = first_p1 ? '0 : acc_p2;
      add_res    = sat_add(base, prod_p1, sgn_p1);
      ovf        = add_res[ACC_W];
      acc_nxt    = add_res[ACC_W-1:0];
      sticky_nxt = (first_p1 ? 1'b0 : sticky_p2) | ovf;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         acc_p2    <= '0;
         sticky_p2 <= 1'b0;
         out_valid <= 1'b0;
         out_data  <= '0;
         out_sat   <= 1'b0;
      end else if (!stall) begin
         out_valid <= vld_p1 && last_p1;
         if (vld_p1) begin
            acc_p2    <= acc_nxt;
            sticky_p2 <= sticky_nxt;
            if (last_p1) begin
               out_data <= acc_nxt;
               out_sat  <= sticky_nxt;
            end
         end
      end
   end

endmodule

// File: tb/tb_mac_pipe_signed.sv
// Directed bench for mac_pipe_signed: three instances (32-bit clamp, 17-bit clamp,
// 17-bit wrap) share stimulus; a reference model fills a scoreboard of results.
module tb_mac_pipe_signed;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic [7:0]  in_a;
   logic [7:0]  in_b;
   logic        in_signed;
   logic        in_first;
   logic        in_last;
   logic        out_ready;

   logic        in_ready_m, in_ready_s, in_ready_w;
   logic        out_valid_m, out_valid_s, out_valid_w;
   logic [31:0] out_data_m;
   logic [16:0] out_data_s, out_data_w;
   logic        out_sat_m, out_sat_s, out_sat_w;

   always #5 clk = ~clk;

   mac_pipe_signed #(.DATA_W(8), .ACC_W(32), .SATURATE(1)) u_m (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_m),
      .in_a(in_a), .in_b(in_b), .in_signed(in_signed), .in_first(in_first),
      .in_last(in_last), .out_valid(out_valid_m), .out_ready(out_ready),
      .out_data(out_data_m), .out_sat(out_sat_m));

   mac_pipe_signed #(.DATA_W(8), .ACC_W(17), .SATURATE(1)) u_s (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_s),
      .in_a(in_a), .in_b(in_b), .in_signed(in_signed), .in_first(in_first),
      .in_last(in_last), .out_valid(out_valid_s), .out_ready(out_ready),
      .out_data(out_data_s), .out_sat(out_sat_s));

   mac_pipe_signed #(.DATA_W(8), .ACC_W(17), .SATURATE(0)) u_w (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_w),
      .in_a(in_a), .in_b(in_b), .in_signed(in_signed), .in_first(in_first),
      .in_last(in_last), .out_valid(out_valid_w), .out_ready(out_ready),
      .out_data(out_data_w), .out_sat(out_sat_w));

   typedef struct packed {
      logic [31:0] d0;
      logic        s0;
      logic [16:0] d1;
      logic        s1;
      logic [16:0] d2;
      logic        s2;
   } exp_t;

   exp_t   q[$];
   int     n_vec  = 0;
   int     n_fail = 0;
   int     mw [3] = '{32, 17, 17};
   bit     msat [3] = '{1'b1, 1'b1, 1'b0};
   longint m_acc [3];
   bit     m_stk [3];
   bit     m_sgn;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      assert (got === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
      end
   endtask

   function automatic void model_reset();
      for (int i = 0; i < 3; i++) begin
         m_acc[i] = 0;
         m_stk[i] = 1'b0;
      end
      m_sgn = 1'b0;
   endfunction

   // Exact-integer reference: compare the true sum against the representable range.
   function automatic void model_beat(input logic [7:0] a, input logic [7:0] b,
                                      input logic s, input logic f, input logic l);
      longint pa, pb, p, base, sum, mx, mn, mask, t0, t1, t2;
      bit     ovf;
      exp_t   e;
      if (f) m_sgn = s;
      pa = (m_sgn && a[7]) ? longint'(a) - 256 : longint'(a);
      pb = (m_sgn && b[7]) ? longint'(b) - 256 : longint'(b);
      p  = pa * pb;
      for (int i = 0; i < 3; i++) begin
         mask = (longint'(1) << mw[i]) - 1;
         if (f)
            base = 0;
         else if (m_sgn && (((m_acc[i] >> (mw[i] - 1)) & 1) == 1))
            base = m_acc[i] - (mask + 1);
         else
            base = m_acc[i];
         sum = base + p;
         if (m_sgn) begin
            mx = (mask + 1) / 2 - 1;
            mn = -((mask + 1) / 2);
         end else begin
            mx = mask;
            mn = 0;
         end
         ovf = (sum > mx) || (sum < mn);
         if (ovf && msat[i]) sum = (sum > mx) ? mx : mn;
         m_acc[i] = sum & mask;
         m_stk[i] = (f ? 1'b0 : m_stk[i]) | ovf;
      end
      if (l) begin
         t0 = m_acc[0];
         t1 = m_acc[1];
         t2 = m_acc[2];
         e.d0 = t0[31:0];
         e.s0 = m_stk[0];
         e.d1 = t1[16:0];
         e.s1 = m_stk[1];
         e.d2 = t2[16:0];
         e.s2 = m_stk[2];
         q.push_back(e);
      end
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic beat(input int a, input int b, input logic s, input logic f, input logic l);
      bit done;
      done      = 1'b0;
      in_valid  = 1'b1;
      in_a      = a[7:0];
      in_b      = b[7:0];
      in_signed = s;
      in_first  = f;
      in_last   = l;
      for (int k = 0; k < 40 && !done; k++) begin
         @(negedge clk);
         if (in_ready_m) begin
            model_beat(in_a, in_b, s, f, l);
            done = 1'b1;
         end
         tick();
      end
      if (!done) chk("beat_accept_timeout", 32'(done), 32'd1);
      in_valid = 1'b0;
   endtask

   task automatic drain();
      for (int k = 0; k < 60 && q.size() != 0; k++) tick();
      chk("drain_queue_empty", 32'(q.size()), 32'd0);
   endtask

   task automatic check_idle_outputs(input string tag);
      chk({tag, "_in_ready"}, 32'(in_ready_m), 32'd1);
      chk({tag, "_out_valid"}, 32'({out_valid_m, out_valid_s, out_valid_w}), 32'd0);
      chk({tag, "_out_data"}, out_data_m | 32'(out_data_s) | 32'(out_data_w), 32'd0);
      chk({tag, "_out_sat"}, 32'({out_sat_m, out_sat_s, out_sat_w}), 32'd0);
   endtask

   initial begin
      exp_t e;
      rst = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0;
      in_signed = 1'b0; in_first = 1'b0; in_last = 1'b0; out_ready = 1'b1;
      model_reset();

      // Scoreboard consumer: every result handshake pops one expectation.
      fork
         forever begin
            @(negedge clk);
            if (!rst && out_valid_m) begin
               if (q.size() == 0) begin
                  chk("unexpected_result", 32'(out_valid_m), 32'd0);
               end else begin
                  e = q[0];
                  chk("data_acc32", out_data_m, e.d0);
                  chk("sat_acc32", 32'(out_sat_m), 32'(e.s0));
                  chk("data_acc17_clamp", 32'(out_data_s), 32'(e.d1));
                  chk("sat_acc17_clamp", 32'(out_sat_s), 32'(e.s1));
                  chk("data_acc17_wrap", 32'(out_data_w), 32'(e.d2));
                  chk("sat_acc17_wrap", 32'(out_sat_w), 32'(e.s2));
                  chk("valid_align", 32'({out_valid_s, out_valid_w}), 32'd3);
                  if (out_ready) void'(q.pop_front());
               end
            end
         end
      join_none

      tick();
      tick();
      @(negedge clk);
      check_idle_outputs("reset");
      rst = 1'b0;
      tick();

      beat(-128, -128, 1'b1, 1'b1, 1'b1);
      @(negedge clk); chk("latency_t1", 32'(out_valid_m), 32'd0);
      @(negedge clk); chk("latency_t2", 32'(out_valid_m), 32'd0);
      @(negedge clk); chk("latency_t3", 32'(out_valid_m), 32'd1);
      tick();
      drain();

      beat(255, 255, 1'b0, 1'b1, 1'b1);
      beat(255, 255, 1'b1, 1'b1, 1'b1);
      drain();

      beat(3, -4, 1'b1, 1'b1, 1'b0);
      beat(-5, 6, 1'b0, 1'b0, 1'b0);
      beat(127, 127, 1'b0, 1'b0, 1'b0);
      beat(-128, 1, 1'b0, 1'b0, 1'b1);
      drain();

      for (int i = 0; i < 4; i++) beat(-128, -128, 1'b1, i == 0, i == 3);
      beat(2, 3, 1'b1, 1'b1, 1'b1);
      for (int i = 0; i < 5; i++) beat(-128, 127, 1'b1, i == 0, i == 4);
      for (int i = 0; i < 3; i++) beat(255, 255, 1'b0, i == 0, i == 2);
      drain();

      out_ready = 1'b0;
      beat(1, 1, 1'b0, 1'b1, 1'b0);
      beat(2, 2, 1'b0, 1'b0, 1'b1);
      beat(3, 3, 1'b0, 1'b1, 1'b0);
      beat(4, 4, 1'b0, 1'b0, 1'b1);
      in_valid = 1'b1; in_a = 8'd7; in_b = 8'd7; in_first = 1'b1; in_last = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("stall_in_ready", 32'({in_ready_m, in_ready_s, in_ready_w}), 32'd0);
      end
      tick();
      out_ready = 1'b1;
      beat(7, 7, 1'b0, 1'b1, 1'b1);
      drain();

      out_ready = 1'b0;
      beat(6, 6, 1'b1, 1'b1, 1'b1);
      tick(); tick(); tick();
      rst = 1'b1;
      tick();
      @(negedge clk);
      check_idle_outputs("reset_in_stall");
      q.delete();
      model_reset();
      rst = 1'b0;
      out_ready = 1'b1;
      tick();

      beat(10, 10, 1'b1, 1'b1, 1'b0);
      rst = 1'b1;
      tick();
      @(negedge clk);
      check_idle_outputs("reset_mid_group");
      q.delete();
      model_reset();
      rst = 1'b0;
      tick();
      beat(2, 2, 1'b1, 1'b0, 1'b1);
      drain();

      repeat (4) tick();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule
